elevator_car_ctrl: RTL and testbench
====================================

Name: elevator_car_ctrl

Overview:
- Car motion and door sequencer that sits directly downstream of the Interface stage.
- Consumes per-floor request pulses and maintains the pending-request set.
- Runs a direction-preserving (SCAN) state machine with travel and door timers.
- Produces the current floor (Level), direction flags and door state, which feed the seven-segment/LED display path.

Parameters:
- TRAVEL_CYCLES, 50_000_000: clock cycles spent in a move state per one-floor step; legal range >=2.
- DOOR_CYCLES, 100_000_000: clock cycles the door stays open per stop; legal range >=2.
- TMR_W, 27: timer width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES)-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- enable  in  1  run enable; low freezes state and timers
- req  in  4  floor request pulses, bit i = floor i; multi-bit allowed
- level  out  2  current floor 0..3
- moving_up  out  1  high in state UP
- moving_down  out  1  high in state DOWN
- door_open  out  1  high in state DOOR
- pending  out  4  latched outstanding requests
- served  out  4  one-cycle pulse on the bit of the floor being served

Behaviour:
- Reset (sync, active-high, overrides enable): state IDLE, level=0, pending=0, served=0, timer=0, last_dir=UP, all flags 0.
- Request latch:
  - pending <= (pending | req) & ~clear_mask, registered; a req at cycle t is visible on pending at t+1.
  - Latching continues while enable=0; only state and timers freeze.
- States: IDLE, UP, DOWN, DOOR. Outputs are registered, decoded from state; exactly one of moving_up/moving_down/door_open is high, or none in IDLE.
- IDLE, evaluated each enabled cycle:
  - pending[level] -> DOOR.
  - else any pending above level -> UP, last_dir=UP.
  - else any pending below -> DOWN, last_dir=DOWN.
  - else stay.
- UP/DOWN:
  - Timer counts 0..TRAVEL_CYCLES-1. On terminal count, level+1 (UP) or level-1 (DOWN) and timer clears.
  - Then with the new level: pending[new level] -> DOOR; else continue if pending remain beyond it in the same direction; else IDLE.
  - level never leaves 0..3: UP is not entered at floor 3, DOWN is not entered at floor 0; no wrap.
- Entry to DOOR:
  - served[level]=1 for exactly that first DOOR cycle.
  - pending[level] cleared in the same edge.
  - Timer starts at 0.
- DOOR:
  - Timer counts to DOOR_CYCLES-1.
  - req[level] during DOOR is not latched; it restarts the timer to 0 and pulses served[level] again.
  - On terminal count: if last_dir=UP and pending above -> UP; else if pending below -> DOWN (last_dir=DOWN); else if pending above -> UP (last_dir=UP); else IDLE.
- req for the current floor while IDLE: latched at t+1, DOOR entered at t+2.
- Simultaneous req on several floors: all latched; served in scan order.
- enable=0 mid-travel or mid-door: state, timer, level and flags hold. Resume continues the count with no restart.
- Reset mid-travel: car snaps to level 0, IDLE (simulation model; no physical travel implied).

Optional Feature:
- Macro CAR_DOOR_HOLD_EN.
- When defined: adds input door_hold (1 bit). While door_hold=1 in DOOR, the timer is held at 0, so the door stays open. On release, a full DOOR_CYCLES elapses before leaving.
- When undefined: the port does not exist, and behaviour is exactly as above.

Test Plan (bench uses TRAVEL_CYCLES=4, DOOR_CYCLES=3):
- Reset, then req=4'b1000 for 1 cycle -> pending=1000 next cycle; moving_up for 12 cycles; level steps 1,2,3 every 4 cycles; door_open with served=1000 pulse; door_open high 3 cycles; IDLE, pending=0.
- At level 0, req=0001 -> pending=0001 next cycle, door_open the cycle after, served=0001 one cycle, no movement.
- Car at 3 (last_dir=UP): req=0101 together -> DOWN; stop at 2; continue DOWN; stop at 0; served pulses 0100 then 0001.
- Moving up from 0 with pending=1000; req=0010 arrives at travel cycle 1 -> car stops at floor 1 (door 3 cycles), then resumes UP to 3.
- enable=0 for 10 cycles mid-travel at timer=2 -> level, timer and moving_up frozen; after enable=1, level increments after exactly 2 more cycles.
- reset asserted while door_open at level 2 with pending=0001 -> next cycle level=0, pending=0, all flags 0, IDLE.

Source files
------------

// File: rtl/elevator_car_ctrl_if.sv
// ---------------------------------------------------------------------------
// elevator_car_ctrl_if
// Bundles the run/request inputs and the car status outputs of the elevator
// car controller.
//   master : request source / display side (drives enable, req)
//   slave  : the car controller (drives level, direction flags, door state,
//            pending set and served pulses)
// Optional: CAR_DOOR_HOLD_EN adds the door_hold input.
// ---------------------------------------------------------------------------
interface elevator_car_ctrl_if;
   logic       enable;
   logic [3:0] req;
   logic [1:0] level;
   logic       moving_up;
   logic       moving_down;
   logic       door_open;
   logic [3:0] pending;
   logic [3:0] served;
`ifdef CAR_DOOR_HOLD_EN
   logic       door_hold;

   modport master (
      output enable, req, door_hold,
      input  level, moving_up, moving_down, door_open, pending, served
   );
   modport slave (
      input  enable, req, door_hold,
      output level, moving_up, moving_down, door_open, pending, served
   );
`else
   modport master (
      output enable, req,
      input  level, moving_up, moving_down, door_open, pending, served
   );
   modport slave (
      input  enable, req,
      output level, moving_up, moving_down, door_open, pending, served
   );
`endif
endinterface

// File: rtl/elevator_car_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_car_ctrl
// Four-floor car motion and door sequencer. Latches per-floor request pulses
// into a pending set and serves them with a direction-preserving (SCAN)
// state machine driven by a travel timer and a door timer.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high; overrides enable
//   car    : elevator_car_ctrl_if.slave
//            enable      - low freezes state, level and timers
//            req[3:0]    - floor request pulses (bit i = floor i)
//            level[1:0]  - current floor
//            moving_up / moving_down / door_open - registered state flags
//            pending[3:0]- latched outstanding requests
//            served[3:0] - one-cycle pulse for the floor whose door opens
// Optional: define CAR_DOOR_HOLD_EN to add car.door_hold, which keeps the
//           door timer at 0 while asserted in DOOR.
// ---------------------------------------------------------------------------
module elevator_car_ctrl #(
   parameter int unsigned TRAVEL_CYCLES = 50_000_000,
   parameter int unsigned DOOR_CYCLES   = 100_000_000,
   parameter int unsigned TMR_W         = 27
) (
   input  logic               clk,
   input  logic               reset,
   elevator_car_ctrl_if.slave car
);

   typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_DOOR} state_t;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
   localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_CYCLES - 1);

   state_t           state;
   dir_t             last_dir;
   logic [1:0]       level;
   logic [TMR_W-1:0] timer;
   logic [3:0]       pend;
   logic [3:0]       served;
   logic             moving_up;
   logic             moving_down;
   logic             door_open;

   logic             door_req;    // request for the open floor: restarts door
   logic [3:0]       req_eff;     // requests that go into the pending set
   logic [1:0]       step_level;  // floor reached at the end of a travel step

   function automatic logic [3:0] floor_bit(input logic [1:0] f);
      return 4'b0001 << f;
   endfunction

   function automatic logic any_above(input logic [3:0] p, input logic [1:0] f);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 4; i++)
         if (i > int'(f) && p[i]) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic any_below(input logic [3:0] p, input logic [1:0] f);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 4; i++)
         if (i < int'(f) && p[i]) hit = 1'b1;
      return hit;
   endfunction

   // {moving_up, moving_down, door_open} for a given state
   function automatic logic [2:0] flags_of(input state_t s);
      return {s == ST_UP, s == ST_DOWN, s == ST_DOOR};
   endfunction

   // NOTE: every signal written here gets a value on every path, so no latch.
   always_comb begin
      door_req   = car.enable && (state == ST_DOOR) && car.req[level];
      req_eff    = door_req ? (car.req & ~floor_bit(level)) : car.req;
      step_level = (state == ST_DOWN) ? level - 2'd1 : level + 2'd1;
   end

   // NOTE: all state is updated with non-blocking assignments; where a later
   // assignment to pend appears below it intentionally overrides the default.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                                <= ST_IDLE;
         last_dir                             <= DIR_UP;
         level                                <= 2'd0;
         timer                                <= '0;
         pend                                 <= 4'b0000;
         served                               <= 4'b0000;
         {moving_up, moving_down, door_open}  <= 3'b000;
      end else begin
         // Requests keep latching even while the car is frozen.
         pend   <= pend | req_eff;
         served <= 4'b0000;
         if (car.enable) begin
            case (state)
               ST_IDLE: begin
                  timer <= '0;
                  if (pend[level]) begin
                     state                               <= ST_DOOR;
                     {moving_up, moving_down, door_open} <= flags_of(ST_DOOR);
                     served                              <= floor_bit(level);
                     pend <= (pend | req_eff) & ~floor_bit(level);
                  end else if (any_above(pend, level)) begin
                     state                               <= ST_UP;
                     {moving_up, moving_down, door_open} <= flags_of(ST_UP);
                     last_dir                            <= DIR_UP;
                  end else if (any_below(pend, level)) begin
                     state                               <= ST_DOWN;
                     {moving_up, moving_down, door_open} <= flags_of(ST_DOWN);
                     last_dir                            <= DIR_DOWN;
                  end
               end

               ST_UP, ST_DOWN: begin
                  if (timer == TRAVEL_LAST) begin
                     timer <= '0;
                     level <= step_level;
                     if (pend[step_level]) begin
                        state                               <= ST_DOOR;
                        {moving_up, moving_down, door_open} <= flags_of(ST_DOOR);
                        served                              <= floor_bit(step_level);
                        pend <= (pend | req_eff) & ~floor_bit(step_level);
                     end else if ((state == ST_UP)   && any_above(pend, step_level)) begin
                        state <= ST_UP;
                     end else if ((state == ST_DOWN) && any_below(pend, step_level)) begin
                        state <= ST_DOWN;
                     end else begin
                        // Nothing beyond the new floor: stopping here also keeps
                        // the car from ever stepping past floor 0 or floor 3.
                        state                               <= ST_IDLE;
                        {moving_up, moving_down, door_open} <= flags_of(ST_IDLE);
                     end
                  end else begin
                     timer <= timer + TMR_W'(1);
                  end
               end

               ST_DOOR: begin
                  if (door_req) begin
                     timer  <= '0;
                     served <= floor_bit(level);
`ifdef CAR_DOOR_HOLD_EN
                  end else if (car.door_hold) begin
                     timer <= '0;
`endif
                  end else if (timer == DOOR_LAST) begin
                     timer <= '0;
                     // Prefer continuing upward if that was the sweep direction.
                     if ((last_dir == DIR_UP) && any_above(pend, level)) begin
                        state                               <= ST_UP;
                        {moving_up, moving_down, door_open} <= flags_of(ST_UP);
                     end else if (any_below(pend, level)) begin
                        state                               <= ST_DOWN;
                        {moving_up, moving_down, door_open} <= flags_of(ST_DOWN);
                        last_dir                            <= DIR_DOWN;
                     end else if (any_above(pend, level)) begin
                        state                               <= ST_UP;
                        {moving_up, moving_down, door_open} <= flags_of(ST_UP);
                        last_dir                            <= DIR_UP;
                     end else begin
                        state                               <= ST_IDLE;
                        {moving_up, moving_down, door_open} <= flags_of(ST_IDLE);
                     end
                  end else begin
                     timer <= timer + TMR_W'(1);
                  end
               end

               default: begin
                  state                               <= ST_IDLE;
                  {moving_up, moving_down, door_open} <= flags_of(ST_IDLE);
               end
            endcase
         end
      end
   end

   assign car.level       = level;
   assign car.moving_up   = moving_up;
   assign car.moving_down = moving_down;
   assign car.door_open   = door_open;
   assign car.pending     = pend;
   assign car.served      = served;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elevator_car_ctrl
// Directed bench for elevator_car_ctrl with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
// Inputs are driven 1 ns after a rising edge and outputs are sampled at the
// same point, so each step() moves exactly one clock cycle.
// flags below is {moving_up, moving_down, door_open}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elevator_car_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   elevator_car_ctrl_if car ();

   elevator_car_ctrl #(
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (3),
      .TMR_W         (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .car   (car)
   );

   logic [2:0] flags;
   assign flags = {car.moving_up, car.moving_down, car.door_open};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      car.enable = 1'b1;
      car.req    = 4'b0000;
`ifdef CAR_DOOR_HOLD_EN
      car.door_hold = 1'b0;
`endif
      step(2);
      reset = 1'b0;
      step(1);
      checks++; if (car.level !== 2'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", car.level); end
      checks++; if (car.pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b exp 0000", car.pending); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", flags); end
      checks++; if (car.served !== 4'b0000) begin errors++; $display("FAIL reset_served got %b exp 0000", car.served); end
   endtask

   // Floor 0 -> 3: 12 cycles of moving_up, then 3 cycles of door at floor 3.
   task automatic test_travel_up();
      car.req = 4'b1000;
      step(1);
      car.req = 4'b0000;
      checks++; if (car.pending !== 4'b1000) begin errors++; $display("FAIL up_latch got %b exp 1000", car.pending); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL up_idle_flags got %b exp 000", flags); end
      step(1);
      for (int k = 0; k < 12; k++) begin
         checks++; if (flags !== 3'b100) begin errors++; $display("FAIL up_moving[%0d] got %b exp 100", k, flags); end
         checks++; if (car.level !== 2'(k / 4)) begin errors++; $display("FAIL up_level[%0d] got %0d exp %0d", k, car.level, k / 4); end
         step(1);
      end
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL up_door got %b exp 001", flags); end
      checks++; if (car.level !== 2'd3) begin errors++; $display("FAIL up_door_level got %0d exp 3", car.level); end
      checks++; if (car.served !== 4'b1000) begin errors++; $display("FAIL up_served got %b exp 1000", car.served); end
      checks++; if (car.pending !== 4'b0000) begin errors++; $display("FAIL up_cleared got %b exp 0000", car.pending); end
      step(1);
      checks++; if (car.served !== 4'b0000) begin errors++; $display("FAIL up_served_pulse got %b exp 0000", car.served); end
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL up_door2 got %b exp 001", flags); end
      step(1);
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL up_door3 got %b exp 001", flags); end
      step(1);
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL up_idle_after got %b exp 000", flags); end
   endtask

   // At floor 3, last_dir=UP: requests on 2 and 0 together are swept downward.
   task automatic test_scan_down();
      car.req = 4'b0101;
      step(1);
      car.req = 4'b0000;
      checks++; if (car.pending !== 4'b0101) begin errors++; $display("FAIL dn_latch got %b exp 0101", car.pending); end
      step(1);
      checks++; if (flags !== 3'b010) begin errors++; $display("FAIL dn_start got %b exp 010", flags); end
      checks++; if (car.level !== 2'd3) begin errors++; $display("FAIL dn_start_level got %0d exp 3", car.level); end
      step(4);
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL dn_stop2 got %b exp 001", flags); end
      checks++; if (car.level !== 2'd2) begin errors++; $display("FAIL dn_stop2_level got %0d exp 2", car.level); end
      checks++; if (car.served !== 4'b0100) begin errors++; $display("FAIL dn_served2 got %b exp 0100", car.served); end
      checks++; if (car.pending !== 4'b0001) begin errors++; $display("FAIL dn_pending2 got %b exp 0001", car.pending); end
      step(3);
      checks++; if (flags !== 3'b010) begin errors++; $display("FAIL dn_resume got %b exp 010", flags); end
      step(4);
      checks++; if (car.level !== 2'd1 || flags !== 3'b010) begin errors++; $display("FAIL dn_pass1 got level %0d flags %b exp level 1 flags 010", car.level, flags); end
      step(4);
      checks++; if (car.level !== 2'd0 || flags !== 3'b001) begin errors++; $display("FAIL dn_stop0 got level %0d flags %b exp level 0 flags 001", car.level, flags); end
      checks++; if (car.served !== 4'b0001) begin errors++; $display("FAIL dn_served0 got %b exp 0001", car.served); end
      step(3);
      checks++; if (flags !== 3'b000 || car.pending !== 4'b0000) begin errors++; $display("FAIL dn_idle got flags %b pending %b exp 000 0000", flags, car.pending); end
   endtask

   // Request at the current floor opens the door; a repeat request reopens it.
   task automatic test_same_floor();
      car.req = 4'b0001;
      step(1);
      car.req = 4'b0000;
      checks++; if (car.pending !== 4'b0001 || flags !== 3'b000) begin errors++; $display("FAIL sf_latch got pending %b flags %b exp 0001 000", car.pending, flags); end
      step(1);
      checks++; if (flags !== 3'b001 || car.level !== 2'd0) begin errors++; $display("FAIL sf_door got flags %b level %0d exp 001 0", flags, car.level); end
      checks++; if (car.served !== 4'b0001 || car.pending !== 4'b0000) begin errors++; $display("FAIL sf_served got served %b pending %b exp 0001 0000", car.served, car.pending); end
      step(1);
      checks++; if (car.served !== 4'b0000) begin errors++; $display("FAIL sf_served_pulse got %b exp 0000", car.served); end
      car.req = 4'b0001;
      step(1);
      car.req = 4'b0000;
      checks++; if (car.served !== 4'b0001 || car.pending !== 4'b0000) begin errors++; $display("FAIL sf_reopen got served %b pending %b exp 0001 0000", car.served, car.pending); end
      step(2);
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL sf_reopen_hold got %b exp 001", flags); end
      step(1);
      checks++; if (flags !== 3'b000 || car.level !== 2'd0) begin errors++; $display("FAIL sf_idle got flags %b level %0d exp 000 0", flags, car.level); end
   endtask

   // Heading to 3, a request for 1 at travel cycle 1 makes the car stop there.
   task automatic test_stop_on_way();
      car.req = 4'b1000;
      step(1);
      car.req = 4'b0000;
      step(1);
      checks++; if (flags !== 3'b100) begin errors++; $display("FAIL sw_start got %b exp 100", flags); end
      step(1);
      car.req = 4'b0010;
      step(1);
      car.req = 4'b0000;
      checks++; if (car.pending !== 4'b1010) begin errors++; $display("FAIL sw_latch got %b exp 1010", car.pending); end
      step(2);
      checks++; if (flags !== 3'b001 || car.level !== 2'd1) begin errors++; $display("FAIL sw_stop1 got flags %b level %0d exp 001 1", flags, car.level); end
      checks++; if (car.served !== 4'b0010 || car.pending !== 4'b1000) begin errors++; $display("FAIL sw_served1 got served %b pending %b exp 0010 1000", car.served, car.pending); end
      step(3);
      checks++; if (flags !== 3'b100 || car.level !== 2'd1) begin errors++; $display("FAIL sw_resume got flags %b level %0d exp 100 1", flags, car.level); end
      step(4);
      checks++; if (flags !== 3'b100 || car.level !== 2'd2) begin errors++; $display("FAIL sw_pass2 got flags %b level %0d exp 100 2", flags, car.level); end
      step(4);
      checks++; if (flags !== 3'b001 || car.level !== 2'd3 || car.served !== 4'b1000) begin errors++; $display("FAIL sw_stop3 got flags %b level %0d served %b exp 001 3 1000", flags, car.level, car.served); end
      step(3);
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL sw_idle got %b exp 000", flags); end
   endtask

   // Freeze for 10 cycles at travel timer=2; leaves the car in DOOR at floor 2
   // with a request for floor 0 still pending.
   task automatic test_enable_freeze();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checks++; if (car.level !== 2'd0 || flags !== 3'b000) begin errors++; $display("FAIL fz_reset got level %0d flags %b exp 0 000", car.level, flags); end
      car.req = 4'b0100;
      step(1);
      car.req = 4'b0000;
      step(1);
      step(2);
      car.enable = 1'b0;
      car.req    = 4'b0001;
      step(1);
      car.req = 4'b0000;
      checks++; if (car.pending !== 4'b0101) begin errors++; $display("FAIL fz_latch got %b exp 0101", car.pending); end
      step(9);
      checks++; if (flags !== 3'b100 || car.level !== 2'd0) begin errors++; $display("FAIL fz_hold got flags %b level %0d exp 100 0", flags, car.level); end
      car.enable = 1'b1;
      step(1);
      checks++; if (car.level !== 2'd0) begin errors++; $display("FAIL fz_resume1 got %0d exp 0", car.level); end
      step(1);
      checks++; if (car.level !== 2'd1 || flags !== 3'b100) begin errors++; $display("FAIL fz_resume2 got level %0d flags %b exp 1 100", car.level, flags); end
      step(4);
      checks++; if (car.level !== 2'd2 || flags !== 3'b001 || car.pending !== 4'b0001) begin errors++; $display("FAIL fz_door2 got level %0d flags %b pending %b exp 2 001 0001", car.level, flags, car.pending); end
   endtask

   // Reset while the door is open at floor 2 snaps the car to floor 0, idle.
   task automatic test_reset_mid_door();
      step(1);
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL rd_pre got %b exp 001", flags); end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      checks++; if (car.level !== 2'd0 || car.pending !== 4'b0000) begin errors++; $display("FAIL rd_state got level %0d pending %b exp 0 0000", car.level, car.pending); end
      checks++; if (flags !== 3'b000 || car.served !== 4'b0000) begin errors++; $display("FAIL rd_flags got flags %b served %b exp 000 0000", flags, car.served); end
      step(3);
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL rd_stays_idle got %b exp 000", flags); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_travel_up();
      test_scan_down();
      test_same_floor();
      test_stop_on_way();
      test_enable_freeze();
      test_reset_mid_door();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
